weight_stream_loader: RTL and testbench

Host-side writer for the accelerator's weight-write bus (`weight_wr_data` / `weight_wr_addr` / `weight_wr_en`).

- Accepts a 32-bit beat stream from the DMA/AXI front end under valid/ready.
- Unpacks each beat into two 16-bit weight words.
- Issues one word per cycle at auto-incrementing addresses, starting from a per-transfer base address.
- Sits between the stream front end and the broadcast weight bus that feeds every PE (kernel, bias, MACC coefficient and layer-scale registers).

---
 rtl/weight_stream_loader.sv | 174 +++++++++++++++++
 tb/tb_weight_stream_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_loader.sv
// weight_stream_loader
//
// Takes a stream of 32-bit beats, splits each beat into two 16-bit weight words and writes them
// one per cycle onto the broadcast weight bus. Addresses auto-increment from a per-transfer base.
//
// Parameters:
//   COUNT_WIDTH  width of the per-transfer word count
//   WORD_ORDER   "low_first" issues s_data[15:0] first, "high_first" issues s_data[31:16] first
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle transfer request, honoured only when idle
//   start_addr        bus address of word 0 of the transfer
//   num_words         number of 16-bit words in the transfer
//   s_data/s_valid    input beat stream
//   s_ready           loader can take a beat
//   weight_wr_*       weight write bus (data, address, one-word strobe)
//   busy              transfer in progress
//   done              one-cycle pulse after the last write of a transfer
module weight_stream_loader #(
    parameter int unsigned COUNT_WIDTH = 20,
    parameter string       WORD_ORDER  = "low_first"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            start_addr,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [15:0]            weight_wr_data,
    output logic [31:0]            weight_wr_addr,
    output logic                   weight_wr_en,
    output logic                   busy,
    output logic                   done
);

    localparam bit HighFirst = (WORD_ORDER == "high_first");

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;      // address of the next word to be written
    logic [COUNT_WIDTH-1:0] num_q, num_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;        // words taken from the stream so far
    logic [COUNT_WIDTH-1:0] iss_q, iss_d;        // words written to the bus so far
    logic [15:0]            hold_q, hold_d;
    logic                   hold_vld_q, hold_vld_d;

    logic [15:0]            wr_data_q, wr_data_d;
    logic [31:0]            wr_addr_q, wr_addr_d;
    logic                   wr_en_q, wr_en_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [15:0]            first_word, second_word;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   emit;
    logic [15:0]            emit_word;

    assign first_word  = HighFirst ? s_data[31:16] : s_data[15:0];
    assign second_word = HighFirst ? s_data[15:0]  : s_data[31:16];
    assign remaining   = num_q - acc_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        num_d      = num_q;
        acc_d      = acc_q;
        iss_d      = iss_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        emit       = 1'b0;
        emit_word  = hold_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = start_addr;
                    num_d      = num_words;
                    acc_d      = '0;
                    iss_d      = '0;
                    hold_vld_d = 1'b0;
                    state_d    = (num_words == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                // s_ready_q is low while the hold register is full, so draining and accepting
                // a new beat never happen in the same cycle.
                if (hold_vld_q) begin
                    emit       = 1'b1;
                    emit_word  = hold_q;
                    hold_vld_d = 1'b0;
                end else if (s_valid && s_ready_q) begin
                    emit      = 1'b1;
                    emit_word = first_word;
                    if (remaining >= COUNT_WIDTH'(2)) begin
                        hold_d     = second_word;
                        hold_vld_d = 1'b1;
                        acc_d      = acc_q + COUNT_WIDTH'(2);
                    end else begin
                        // Odd tail: the second half of the last beat is dropped.
                        acc_d = acc_q + COUNT_WIDTH'(1);
                    end
                end
                if (emit) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = emit_word;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + 32'd1;
                    iss_d     = iss_q + COUNT_WIDTH'(1);
                end
                if (iss_d == num_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        s_ready_d = (state_d == StLoad) && !hold_vld_d && (acc_d != num_d);
        // busy stays up through the done pulse and drops the cycle after it.
        busy_d    = (state_d != StIdle) || (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            num_q      <= '0;
            acc_q      <= '0;
            iss_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            iss_q      <= iss_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_ready        = s_ready_q;
    assign weight_wr_data = wr_data_q;
    assign weight_wr_addr = wr_addr_q;
    assign weight_wr_en   = wr_en_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Bench for weight_stream_loader: one low_first and one high_first instance share all inputs.
// Expected writes and done pulses are queued per instance when a transfer is issued; a negedge
// monitor pops and compares whenever an instance writes or signals done.
module tb_weight_stream_loader;

    localparam int unsigned CW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   start_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;

    logic          s_ready [2];
    logic [15:0]   wr_data [2];
    logic [31:0]   wr_addr [2];
    logic          wr_en   [2];
    logic          busy    [2];
    logic          done    [2];

    weight_stream_loader #(.COUNT_WIDTH(CW), .WORD_ORDER("low_first")) u_dut_lo (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_words(num_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[0]),
        .weight_wr_data(wr_data[0]), .weight_wr_addr(wr_addr[0]), .weight_wr_en(wr_en[0]),
        .busy(busy[0]), .done(done[0])
    );

    weight_stream_loader #(.COUNT_WIDTH(CW), .WORD_ORDER("high_first")) u_dut_hi (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_words(num_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[1]),
        .weight_wr_data(wr_data[1]), .weight_wr_addr(wr_addr[1]), .weight_wr_en(wr_en[1]),
        .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic [31:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [2][$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_addr [2];
    logic [15:0] last_data [2];

    task automatic check(input string name, input int dut, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%08h, required 0x%08h (t=%0t)", name, dut, act, req,
                     $time);
        end
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 2; d++) begin
            check({name, "_s_ready"}, d, 32'(s_ready[d]), 32'd0);
            check({name, "_wr_en"},   d, 32'(wr_en[d]),   32'd0);
            check({name, "_wr_data"}, d, 32'(wr_data[d]), 32'd0);
            check({name, "_wr_addr"}, d, wr_addr[d],      32'd0);
            check({name, "_busy"},    d, 32'(busy[d]),    32'd0);
            check({name, "_done"},    d, 32'(done[d]),    32'd0);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                last_addr[d] = '0;
                last_data[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wr_en[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write dut%0d: got addr 0x%08h data 0x%04h, required no write",
                                 d, wr_addr[d], wr_data[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        check("write_expected", d, 32'(e.is_done), 32'd0);
                        check("wr_addr", d, wr_addr[d], e.addr);
                        check("wr_data", d, 32'(wr_data[d]), 32'(e.data));
                        last_addr[d] = e.addr;
                        last_data[d] = e.data;
                    end
                end else begin
                    check("idle_addr_hold", d, wr_addr[d], last_addr[d]);
                    check("idle_data_hold", d, 32'(wr_data[d]), 32'(last_data[d]));
                end
                if (done[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done dut%0d: got done=1, required done=0", d);
                    end else begin
                        e = exp_q[d].pop_front();
                        check("done_expected", d, 32'(e.is_done), 32'd1);
                    end
                end
            end
        end
    end

    // stall: 0 = s_valid always high, 1 = random, 2 = repeating 1,0,0,1
    task automatic run_transfer(input logic [31:0] addr, input int n, input int stall,
                                input bit poke_start, input bit fixed,
                                input logic [31:0] b0, input logic [31:0] b1);
        logic [31:0] beats [$];
        logic [31:0] b;
        exp_t        e;
        int          nbeats;
        int          cyc;
        int          hs;
        int          latency;
        bit          got_done;
        bit          pat [4];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        nbeats = (n + 1) / 2;
        for (int i = 0; i < nbeats; i++) begin
            if (fixed && i == 0)      beats.push_back(b0);
            else if (fixed && i == 1) beats.push_back(b1);
            else                      beats.push_back($urandom);
        end
        // Word i goes to addr + i; even i is the first half of beat i/2 in issue order.
        for (int i = 0; i < n; i++) begin
            b = beats[i / 2];
            e.is_done = 1'b0;
            e.addr    = addr + 32'(i);
            e.data    = (i % 2 == 0) ? b[15:0] : b[31:16];
            exp_q[0].push_back(e);
            e.data    = (i % 2 == 0) ? b[31:16] : b[15:0];
            exp_q[1].push_back(e);
        end
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q[0].push_back(e);
        exp_q[1].push_back(e);

        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = addr;
        num_words  = CW'(n);
        s_valid    = 1'b0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = $urandom;
        num_words  = CW'($urandom);

        cyc      = 0;
        hs       = 0;
        latency  = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 4 * n + 20) begin
            case (stall)
                0:       s_valid = 1'b1;
                1:       s_valid = ($urandom % 3) != 0;
                default: s_valid = pat[cyc % 4];
            endcase
            s_data = (hs < nbeats) ? beats[hs] : $urandom;
            if (poke_start && cyc == 3) begin
                start      = 1'b1;
                start_addr = $urandom;
                num_words  = CW'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("busy_after_start", 0, 32'(busy[0]), 32'd1);
                if (n > 0) check("s_ready_after_start", 0, 32'(s_ready[0]), 32'd1);
            end
            if (n == 0) check("zero_len_s_ready", 0, 32'(s_ready[0]), 32'd0);
            if (done[0]) begin
                got_done = 1'b1;
                latency  = cyc;
                check("busy_in_done_cycle", 0, 32'(busy[0]), 32'd1);
            end
            if (s_valid && s_ready[0]) hs++;
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        s_valid = 1'b0;

        if (!got_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done for n=%0d",
                     cyc, n);
        end else begin
            check("handshakes", 0, 32'(hs), 32'(nbeats));
            if (stall == 0) check("done_latency", 0, 32'(latency), 32'(n + 2));
            @(negedge clk);
            check("busy_after_done", 0, 32'(busy[0]), 32'd0);
            check("done_one_cycle", 0, 32'(done[0]), 32'd0);
            for (int d = 0; d < 2; d++) begin
                check("scoreboard_drained", d, 32'(exp_q[d].size()), 32'd0);
            end
        end
    endtask

    task automatic reset_mid_transfer();
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 32'h100;
        num_words  = CW'(4);
        s_valid    = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        @(posedge clk);   // beat accepted here; second word now waits in the hold register
        #2;
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = $urandom;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("post_reset_s_ready", d, 32'(s_ready[d]), 32'd0);
                check("post_reset_wr_en", d, 32'(wr_en[d]), 32'd0);
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = $urandom;
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("release_s_ready", d, 32'(s_ready[d]), 32'd0);
                check("release_wr_en", d, 32'(wr_en[d]), 32'd0);
            end
        end
        s_valid = 1'b0;

        run_transfer(32'd23, 4, 0, 1'b0, 1'b1, 32'h0002_0001, 32'h0004_0003);
        run_transfer(32'h10, 3, 0, 1'b0, 1'b1, 32'hAAAA_BBBB, 32'hCCCC_DDDD);
        run_transfer(32'h200, 8, 2, 1'b0, 1'b0, '0, '0);
        run_transfer(32'hFFFF_FFFF, 2, 0, 1'b0, 1'b0, '0, '0);
        run_transfer(32'h300, 9, 0, 1'b1, 1'b0, '0, '0);
        run_transfer(32'h400, 0, 0, 1'b0, 1'b0, '0, '0);
        reset_mid_transfer();
        run_transfer(32'h500, 5, 0, 1'b0, 1'b0, '0, '0);

        for (int t = 0; t < 12; t++) begin
            run_transfer((($urandom % 4) == 0) ? (32'hFFFF_FFF8 + 32'($urandom % 8)) : $urandom,
                         int'($urandom % 13), 1, 1'b0, 1'b0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
